pc_sequencer: RTL

Fetch-stage controller for the 5-stage Y86-64 pipeline. It owns the predicted-PC register feeding instruction fetch and selects the next PC from fetch outputs, mispredicted-branch recovery, or return-address writeback. It sequences fetch through run, return-wait, halt-drain and terminal states, and generates the fetch-stall and decode-bubble controls for the F/D pipeline registers.

---
 rtl/pc_sequencer_pkg.sv | 55 +++++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer_pc_select.sv | 63 ++++++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for pc_sequencer: Y86-64 icodes, status codes, sequencer
// states and the per-cycle decision made by the next-PC selector.
package pc_sequencer_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_STOPPED  = 2'd3
    } seq_state_e;

    typedef enum logic [3:0] {
        EV_PREDICT,
        EV_LOAD_USE,
        EV_FAULT,
        EV_RET,
        EV_MISPRED,
        EV_RET_WAIT,
        EV_RET_DONE,
        EV_DRAIN,
        EV_STOP,
        EV_STOPPED
    } seq_event_e;

    // Address errors mask decode errors, which mask a legal halt.
    function automatic logic [2:0] fetch_stat(input logic [3:0] icode,
                                              input logic       instr_valid,
                                              input logic       imem_error);
        logic [2:0] stat;
        if (imem_error)        stat = SADR;
        else if (!instr_valid) stat = SINS;
        else if (icode == IHALT) stat = SHLT;
        else                   stat = SAOK;
        return stat;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control bus between the pipeline stages and pc_sequencer.
interface pc_sequencer_if;

    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_instr_valid;
    logic        f_imem_error;
    logic        d_load_use;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valA;
    logic [3:0]  w_icode;
    logic [2:0]  w_stat;
    logic [63:0] w_valM;
    logic [63:0] pc;
    logic        f_stall;
    logic        d_bubble;
    logic [2:0]  f_stat;
    logic [1:0]  seq_state;

    modport master (
        output f_icode, f_valC, f_valP, f_instr_valid, f_imem_error, d_load_use,
               m_icode, m_cnd, m_valA, w_icode, w_stat, w_valM,
        input  pc, f_stall, d_bubble, f_stat, seq_state
    );

    modport slave (
        input  f_icode, f_valC, f_valP, f_instr_valid, f_imem_error, d_load_use,
               m_icode, m_cnd, m_valA, w_icode, w_stat, w_valM,
        output pc, f_stall, d_bubble, f_stat, seq_state
    );

endinterface

// File: rtl/pc_sequencer_pc_select.sv
// Combinational next-PC mux: resolves the priority between mispredict
// recovery, ret writeback, hazards, faults and fetch-side prediction.
module pc_sequencer_pc_select
    import pc_sequencer_pkg::*;
(
    input  seq_state_e  state,
    input  logic [63:0] pc_q,
    input  logic [3:0]  f_icode,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_instr_valid,
    input  logic        f_imem_error,
    input  logic        d_load_use,
    input  logic [3:0]  m_icode,
    input  logic        m_cnd,
    input  logic [63:0] m_valA,
    input  logic [3:0]  w_icode,
    input  logic [2:0]  w_stat,
    input  logic [63:0] w_valM,
    output seq_event_e  ev,
    output logic [63:0] pc_d
);

    logic mispred;
    logic fault;

    assign mispred = (m_icode == IJXX) && !m_cnd;
    assign fault   = f_imem_error || !f_instr_valid || (f_icode == IHALT);

    always_comb begin
        ev   = EV_STOPPED;
        pc_d = pc_q;
        if (state == ST_STOPPED) begin
            ev = EV_STOPPED;
        end else if (mispred) begin
            ev   = EV_MISPRED;
            pc_d = m_valA;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (d_load_use)           ev = EV_LOAD_USE;
                    else if (fault)           ev = EV_FAULT;
                    else if (f_icode == IRET) ev = EV_RET;
                    else begin
                        ev   = EV_PREDICT;
                        pc_d = (f_icode == IJXX || f_icode == ICALL) ? f_valC : f_valP;
                    end
                end
                ST_RET_WAIT: begin
                    if (w_icode == IRET) begin
                        ev   = EV_RET_DONE;
                        pc_d = w_valM;
                    end else begin
                        ev = EV_RET_WAIT;
                    end
                end
                ST_DRAIN: ev = (w_stat != SAOK) ? EV_STOP : EV_DRAIN;
                default:  ev = EV_STOPPED;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register and run/ret-wait/drain/stopped sequencer.
// Optional PC_SEQ_PERF_EN adds saturating cycle/stall/mispredict counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] MAX_PC   = 64'd511
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls,
    output logic [15:0] perf_mispred,
`endif
    pc_sequencer_if.slave bus
);

    seq_state_e  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    seq_event_e  ev;
    logic        stall_c;
    logic        bubble_c;

    pc_sequencer_pc_select u_pc_select (
        .state         (state_q),
        .pc_q          (pc_q),
        .f_icode       (bus.f_icode),
        .f_valC        (bus.f_valC),
        .f_valP        (bus.f_valP),
        .f_instr_valid (bus.f_instr_valid),
        .f_imem_error  (bus.f_imem_error),
        .d_load_use    (bus.d_load_use),
        .m_icode       (bus.m_icode),
        .m_cnd         (bus.m_cnd),
        .m_valA        (bus.m_valA),
        .w_icode       (bus.w_icode),
        .w_stat        (bus.w_stat),
        .w_valM        (bus.w_valM),
        .ev            (ev),
        .pc_d          (pc_d)
    );

    // The instruction that triggers a stall (ret, halt/fault, load/use) still
    // enters D; only the cycles after it are bubbled.
    always_comb begin
        state_d  = state_q;
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        unique case (ev)
            EV_PREDICT: begin
                stall_c  = 1'b0;
                bubble_c = 1'b0;
            end
            EV_LOAD_USE: bubble_c = 1'b0;
            EV_FAULT: begin
                bubble_c = 1'b0;
                state_d  = ST_DRAIN;
            end
            EV_RET: begin
                bubble_c = 1'b0;
                state_d  = ST_RET_WAIT;
            end
            EV_MISPRED: begin
                stall_c = 1'b0;
                state_d = ST_RUN;
            end
            EV_RET_DONE: state_d = ST_RUN;
            EV_STOP:     state_d = ST_STOPPED;
            default:     state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.seq_state = state_q;
    assign bus.f_stall   = stall_c;
    assign bus.d_bubble  = bubble_c;
    assign bus.f_stat    = (state_q == ST_RUN || state_q == ST_DRAIN)
                         ? fetch_stat(bus.f_icode, bus.f_instr_valid, bus.f_imem_error)
                         : SAOK;

    // Range checking belongs to fetch; this block only relies on it.
    imem_range_a: assert property (@(posedge clk) disable iff (rst)
        (pc_q > MAX_PC) |-> bus.f_imem_error);

`ifdef PC_SEQ_PERF_EN
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] stalls_q, stalls_d;
    logic [15:0] mispred_q, mispred_d;

    always_comb begin
        cycles_d  = cycles_q;
        stalls_d  = stalls_q;
        mispred_d = mispred_q;
        if (state_q != ST_STOPPED && cycles_q != '1) cycles_d  = cycles_q + 32'd1;
        if (stall_c && stalls_q != '1)               stalls_d  = stalls_q + 32'd1;
        if (ev == EV_MISPRED && mispred_q != '1)     mispred_d = mispred_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q  <= '0;
            stalls_q  <= '0;
            mispred_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            stalls_q  <= stalls_d;
            mispred_q <= mispred_d;
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_stalls  = stalls_q;
    assign perf_mispred = mispred_q;
`endif

endmodule
